// File: rtl/hazard_ctrl_if.sv
// Bus between the ID-stage decoder/datapath and the hazard/pipeline control
// block. The slave side is the control block; the master side is whatever
// drives the ID-stage fields and consumes the stage controls.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
) ();
  // ID-stage inputs
  logic [9:0]        id_ctrl;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              ex_zero;
  // Front-end control
  logic              en_reg;
  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic [1:0]        pc_sel;
  // Stage registers
  logic [9:0]        ex_ctrl;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [3:0]        mem_ctrl;
  logic [REG_AW-1:0] mem_dest;
  logic [1:0]        wb_ctrl;
  logic [REG_AW-1:0] wb_dest;
  // Forwarding selects
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport slave (
    input  id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    output en_reg, pc_we, ifid_we, ifid_flush, pc_sel,
    output ex_ctrl, ex_rs, ex_rt, mem_ctrl, mem_dest, wb_ctrl, wb_dest,
    output fwd_a, fwd_b
  );

  modport master (
    output id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    input  en_reg, pc_we, ifid_we, ifid_flush, pc_sel,
    input  ex_ctrl, ex_rs, ex_rt, mem_ctrl, mem_dest, wb_ctrl, wb_dest,
    input  fwd_a, fwd_b
  );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// 5-stage MIPS pipeline control: carries decoder control through ID/EX,
// EX/MEM and MEM/WB, detects load-use hazards, resolves branch/jump
// redirects and produces EX-stage forwarding selects.
module hazard_ctrl_pipe #(
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  ctrl_t             w_id_ctrl;
  ctrl_t             r_ex_ctrl;
  logic [REG_AW-1:0] r_ex_rs, r_ex_rt, r_ex_rd;
  logic [3:0]        r_mem_ctrl;
  logic [REG_AW-1:0] r_mem_dest;
  logic [1:0]        r_wb_ctrl;
  logic [REG_AW-1:0] r_wb_dest;

  logic [REG_AW-1:0] w_ex_dest;
  logic              w_stall;
  logic              w_take_br;
  logic              w_take_j;
  logic              w_bubble;
  logic [1:0]        w_fwd_a, w_fwd_b;

  assign w_id_ctrl = ctrl_t'(bus.id_ctrl);
  assign w_ex_dest = r_ex_ctrl.reg_dst ? r_ex_rd : r_ex_rt;

  // Hazard and redirect decisions. Nothing here looks at id_ctrl except the
  // jump, so en_reg never loops back through the decoder. The jump is held
  // off while stalled (it stays in ID) and under reset (front end idle).
  always_comb begin
    w_stall   = r_ex_ctrl.mem_read && (r_ex_rt != '0) &&
                ((r_ex_rt == bus.id_rs) || (r_ex_rt == bus.id_rt));
    w_take_br = r_ex_ctrl.branch && bus.ex_zero;
    w_take_j  = w_id_ctrl.jump && !w_take_br && !w_stall && !rst;
    w_bubble  = w_stall || w_take_br;
  end

  // EX/MEM wins over MEM/WB since it holds the younger result; $0 never forwards.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_mem_ctrl[2] && (r_mem_dest != '0) && (r_mem_dest == r_ex_rs))
      w_fwd_a = 2'b10;
    else if (r_wb_ctrl[0] && (r_wb_dest != '0) && (r_wb_dest == r_ex_rs))
      w_fwd_a = 2'b01;
    if (r_mem_ctrl[2] && (r_mem_dest != '0) && (r_mem_dest == r_ex_rt))
      w_fwd_b = 2'b10;
    else if (r_wb_ctrl[0] && (r_wb_dest != '0) && (r_wb_dest == r_ex_rt))
      w_fwd_b = 2'b01;
  end

  // ID/EX: loads a full bubble on a stall or a taken branch, else the ID fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_ctrl <= '0;
      r_ex_rs   <= '0;
      r_ex_rt   <= '0;
      r_ex_rd   <= '0;
    end else if (w_bubble) begin
      r_ex_ctrl <= '0;
      r_ex_rs   <= '0;
      r_ex_rt   <= '0;
      r_ex_rd   <= '0;
    end else begin
      r_ex_ctrl <= w_id_ctrl;
      r_ex_rs   <= bus.id_rs;
      r_ex_rt   <= bus.id_rt;
      r_ex_rd   <= bus.id_rd;
    end
  end

  // EX/MEM and MEM/WB free-run: nothing past EX is ever stalled or flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_ctrl <= '0;
      r_mem_dest <= '0;
      r_wb_ctrl  <= '0;
      r_wb_dest  <= '0;
    end else begin
      r_mem_ctrl <= {r_ex_ctrl.mem_to_reg, r_ex_ctrl.reg_write,
                     r_ex_ctrl.mem_read, r_ex_ctrl.mem_write};
      r_mem_dest <= w_ex_dest;
      r_wb_ctrl  <= r_mem_ctrl[3:2];
      r_wb_dest  <= r_mem_dest;
    end
  end

  assign bus.en_reg     = !w_stall || w_take_br;
  assign bus.pc_we      = !w_stall || w_take_br;
  assign bus.ifid_we    = !w_stall || w_take_br;
  assign bus.ifid_flush = w_take_br || w_take_j;
  assign bus.pc_sel     = w_take_br ? 2'b01 : (w_take_j ? 2'b10 : 2'b00);
  assign bus.ex_ctrl    = r_ex_ctrl;
  assign bus.ex_rs      = r_ex_rs;
  assign bus.ex_rt      = r_ex_rt;
  assign bus.mem_ctrl   = r_mem_ctrl;
  assign bus.mem_dest   = r_mem_dest;
  assign bus.wb_ctrl    = r_wb_ctrl;
  assign bus.wb_dest    = r_wb_dest;
  assign bus.fwd_a      = w_fwd_a;
  assign bus.fwd_b      = w_fwd_b;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: directed vector table, hand sequences for
// reset/stall corners, then random traffic against an instruction-level model.
module tb_hazard_ctrl_pipe;
  localparam int AW = 5;
  localparam logic [9:0] OP_NOP  = 10'b0000000000;
  localparam logic [9:0] OP_R    = 10'b1001000010;
  localparam logic [9:0] OP_LW   = 10'b0111100000;
  localparam logic [9:0] OP_SW   = 10'b0100010000;
  localparam logic [9:0] OP_BEQ  = 10'b0000001001;
  localparam logic [9:0] OP_J    = 10'b0000000100;
  localparam logic [9:0] OP_ADDI = 10'b0101000000;
  localparam logic [9:0] OP_BRLD = 10'b0000101001; // branch+load, corner only

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW)) bus ();
  hazard_ctrl_pipe #(.REG_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z);
    bus.id_ctrl = c; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.ex_zero = z;
  endtask

  // {en,pc_we,ifid_we,flush,pc_sel,fwd_a,fwd_b,ex_ctrl,ex_rs,ex_rt,mem_ctrl,mem_dest,wb_ctrl,wb_dest}
  function automatic logic [45:0] dut_vec();
    return {bus.en_reg, bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.pc_sel, bus.fwd_a,
            bus.fwd_b, bus.ex_ctrl, bus.ex_rs, bus.ex_rt, bus.mem_ctrl, bus.mem_dest,
            bus.wb_ctrl, bus.wb_dest};
  endfunction

  // front-end view: {en,pc_we,ifid_we,flush,pc_sel,fwd_a,fwd_b,ex_ctrl}
  function automatic logic [19:0] fe_vec();
    return {bus.en_reg, bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.pc_sel,
            bus.fwd_a, bus.fwd_b, bus.ex_ctrl};
  endfunction

  typedef struct packed {
    logic [9:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       zero;
    logic       en;
    logic [1:0] pc_sel;
    logic       flush;
    logic [1:0] fa, fb;
    logic [9:0] ex_ctrl;
  } vec_t;

  function automatic vec_t mk(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic z, input logic en,
                              input logic [1:0] ps, input logic fl, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [9:0] exc);
    vec_t v;
    v.ctrl = c; v.rs = rs; v.rt = rt; v.rd = rd; v.zero = z; v.en = en;
    v.pc_sel = ps; v.flush = fl; v.fa = fa; v.fb = fb; v.ex_ctrl = exc;
    return v;
  endfunction

  // Instruction-level model: each stage holds the whole instruction that is in it.
  typedef struct packed {
    logic [9:0] c;
    logic [4:0] rs, rt, rd;
  } ins_t;
  ins_t pipe [3]; // 0 = EX, 1 = MEM, 2 = WB

  function automatic logic [4:0] dest_of(input ins_t x);
    return x.c[9] ? x.rd : x.rt;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (pipe[1].c[6] && dest_of(pipe[1]) == src) return 2'b10;
    if (pipe[2].c[6] && dest_of(pipe[2]) == src) return 2'b01;
    return 2'b00;
  endfunction

  vec_t tbl [25];

  initial begin
    rst = 1'b1;
    drive(OP_J, 5'd0, 5'd0, 5'd0, 1'b1);
    #12;
    // reset state, even with a jump sitting in ID
    check("reset_state", 64'(dut_vec()), 64'({3'b111, 43'b0}));

    // rows after release: id fields applied, expected comb outputs at that cycle
    tbl[0]  = mk(OP_LW,   0, 8, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);
    tbl[1]  = mk(OP_R,    8, 2, 9, 0, 0, 2'b00, 0, 2'b00, 2'b00, OP_LW);   // load-use
    tbl[2]  = mk(OP_R,    8, 2, 9, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);  // bubble in EX
    tbl[3]  = mk(OP_NOP,  0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b00, OP_R);    // add gets WB fwd
    tbl[4]  = mk(OP_ADDI, 0, 5, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);
    tbl[5]  = mk(OP_ADDI, 0, 5, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_ADDI);
    tbl[6]  = mk(OP_R,    5, 5,10, 0, 1, 2'b00, 0, 2'b00, 2'b10, OP_ADDI);
    tbl[7]  = mk(OP_ADDI, 0, 5, 0, 0, 1, 2'b00, 0, 2'b10, 2'b10, OP_R);    // MEM over WB
    tbl[8]  = mk(OP_SW,   0, 5, 0, 0, 1, 2'b00, 0, 2'b00, 2'b01, OP_ADDI);
    tbl[9]  = mk(OP_R,    5, 0,12, 0, 1, 2'b00, 0, 2'b00, 2'b10, OP_SW);
    tbl[10] = mk(OP_NOP,  0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b00, OP_R);    // MEM no write
    tbl[11] = mk(OP_ADDI, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);
    tbl[12] = mk(OP_ADDI, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_ADDI);
    tbl[13] = mk(OP_R,    0, 3, 4, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_ADDI);
    tbl[14] = mk(OP_NOP,  0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_R);    // dest $0
    tbl[15] = mk(OP_BEQ,  1, 2, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);
    tbl[16] = mk(OP_R,    1, 2, 3, 1, 1, 2'b01, 1, 2'b00, 2'b00, OP_BEQ);  // taken
    tbl[17] = mk(OP_NOP,  0, 0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);  // squashed
    tbl[18] = mk(OP_BEQ,  1, 2, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);
    tbl[19] = mk(OP_NOP,  0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_BEQ);  // not taken
    tbl[20] = mk(OP_BRLD, 0, 8, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);
    tbl[21] = mk(OP_R,    8, 1, 2, 1, 1, 2'b01, 1, 2'b00, 2'b00, OP_BRLD); // br beats stall
    tbl[22] = mk(OP_NOP,  0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_NOP);
    tbl[23] = mk(OP_J,    0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 2'b00, OP_NOP);  // jump
    tbl[24] = mk(OP_NOP,  0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, OP_J);

    @(negedge clk);
    rst = 1'b0;
    drive(OP_NOP, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].zero);
      #1;
      check($sformatf("vec%0d", i), 64'(fe_vec()),
            64'({tbl[i].en, tbl[i].en, tbl[i].en, tbl[i].flush, tbl[i].pc_sel,
                 tbl[i].fa, tbl[i].fb, tbl[i].ex_ctrl}));
    end

    // mid-stall asynchronous reset, then a clean lw/add sequence
    @(negedge clk); drive(OP_LW, 0, 8, 0, 0);
    @(negedge clk); drive(OP_R, 8, 2, 9, 0); #1;
    check("pre_rst_stall", 64'(fe_vec()), 64'({3'b000, 1'b0, 2'b00, 4'b0000, OP_LW}));
    #2 rst = 1'b1; #1;
    check("mid_stall_rst", 64'(dut_vec()), 64'({3'b111, 43'b0}));
    @(negedge clk); rst = 1'b0; drive(OP_LW, 0, 8, 0, 0); #1;
    check("post_rst_idle", 64'(dut_vec()), 64'({3'b111, 43'b0}));
    @(negedge clk); drive(OP_R, 8, 2, 9, 0); #1;
    check("post_rst_stall", 64'(fe_vec()), 64'({3'b000, 1'b0, 2'b00, 4'b0000, OP_LW}));
    @(negedge clk); #1;
    check("post_rst_bubble", 64'(fe_vec()), 64'({3'b111, 1'b0, 2'b00, 4'b0000, OP_NOP}));
    check("post_rst_memlw", 64'({bus.mem_ctrl, bus.mem_dest}), 64'({4'b1110, 5'd8}));
    @(negedge clk); drive(OP_NOP, 0, 0, 0, 0); #1;
    check("post_rst_fwd", 64'(fe_vec()), 64'({3'b111, 1'b0, 2'b00, 4'b0100, OP_R}));
    check("post_rst_wblw", 64'({bus.wb_ctrl, bus.wb_dest}), 64'({2'b11, 5'd8}));

    // random traffic against the instruction-level model
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    begin
      logic [9:0] ops [7];
      int         nerr;
      ops = '{OP_NOP, OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
      nerr = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        logic [9:0]  c;
        logic [4:0]  rs, rt, rd;
        logic        z, stall, br, jmp, en;
        logic [1:0]  ps;
        logic [45:0] exp_v;
        @(negedge clk);
        c  = ops[$urandom_range(0, 6)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        z  = 1'($urandom_range(0, 1));
        drive(c, rs, rt, rd, z);
        #1;
        stall = pipe[0].c[5] && pipe[0].rt != 0 && (pipe[0].rt == rs || pipe[0].rt == rt);
        br    = pipe[0].c[3] && z;
        jmp   = c[2] && !br && !stall;
        en    = br || !stall;
        ps    = br ? 2'b01 : (jmp ? 2'b10 : 2'b00);
        exp_v = {en, en, en, br || jmp, ps, fwd_of(pipe[0].rs), fwd_of(pipe[0].rt),
                 pipe[0].c, pipe[0].rs, pipe[0].rt,
                 pipe[1].c[7], pipe[1].c[6], pipe[1].c[5], pipe[1].c[4], dest_of(pipe[1]),
                 pipe[2].c[7], pipe[2].c[6], dest_of(pipe[2])};
        if (dut_vec() !== exp_v && nerr < 10) nerr++;
        if (dut_vec() !== exp_v || cyc % 50 == 0)
          check($sformatf("rand%0d", cyc), 64'(dut_vec()), 64'(exp_v));
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (br || stall) ? '0 : ins_t'({c, rs, rt, rd});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
